fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 6-stage MIPS pipeline, sitting directly upstream of the combinational `decode` block. It owns the program counter and issues requests to instruction memory over a valid/ack handshake. It presents the fetched word on `inscode` together with its PC, and absorbs stalls, flushes and control-flow redirects from later stages. A one-entry skid register prevents loss of an instruction that returns while the stage is stalled.

---
 rtl/fetch_stage.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem valid/ack request FSM and IF/ID register with one-entry skid.
// Optional macro FETCH_JUMP_PREDECODE_EN: J words redirect the PC at ack time (no jump bubble).
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        jump_valid,
   input  logic [25:0] jump_address,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inscode,
   output logic [31:0] pc_out,
   output logic        inscode_valid
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] addr_q;
   logic        req_q;
   logic [31:0] ins_q;
   logic [31:0] pco_q;
   logic        valid_q;
   logic [31:0] skid_q;
   logic [31:0] skid_pc_q;

   logic        redirect_s;
   logic        jump_take_s;
   logic        predec_s;
   logic        accept_s;
   logic        if_free_s;
   logic [31:0] target_s;
   logic [31:0] pc_next_s;
   logic [31:0] pco_plus4_s;
   logic [31:0] fpc_plus4_s;
   logic        unused_s;

`ifdef FETCH_JUMP_PREDECODE_EN
   logic        jpre_q;

   // A decode-side jump for a word already redirected at ack time must not redirect again.
   assign jump_take_s = jump_valid && !jpre_q;
   assign predec_s    = (imem_rdata[31:26] == 6'b000010);
`else
   assign jump_take_s = jump_valid;
   assign predec_s    = 1'b0;
`endif

   assign unused_s = ^{branch_target[1:0], pco_plus4_s[27:0]};

   // Redirect target selection and next fetch PC.
   always_comb begin
      pco_plus4_s = pco_q + 32'd4;
      fpc_plus4_s = pc_q + 32'd4;
      if_free_s   = !valid_q || !stall;
      if (branch_valid) begin
         redirect_s = 1'b1;
         target_s   = {branch_target[31:2], 2'b00};
      end else if (jump_take_s) begin
         redirect_s = 1'b1;
         target_s   = {pco_plus4_s[31:28], jump_address, 2'b00};
      end else begin
         redirect_s = 1'b0;
         target_s   = pc_q;
      end
      accept_s = (state_q == ST_FETCH) && imem_ack && !redirect_s && !flush;
      if (redirect_s) begin
         pc_next_s = target_s;
      end else if (accept_s && predec_s) begin
         pc_next_s = {fpc_plus4_s[31:28], imem_rdata[25:0], 2'b00};
      end else if (accept_s) begin
         pc_next_s = fpc_plus4_s;
      end else begin
         pc_next_s = pc_q;
      end
   end

   // Fetch FSM: PC, request handshake and skid capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         req_q     <= 1'b0;
         skid_q    <= 32'h0;
         skid_pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_next_s;
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
               req_q   <= 1'b1;
               addr_q  <= pc_next_s;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  if (accept_s && !if_free_s) begin
                     state_q   <= ST_HOLD;
                     req_q     <= 1'b0;
                     skid_q    <= imem_rdata;
                     skid_pc_q <= addr_q;
                  end else begin
                     state_q <= ST_FETCH;
                     req_q   <= 1'b1;
                     addr_q  <= pc_next_s;
                  end
               end else if (redirect_s) begin
                  // Address stays put until the stale request is acked.
                  state_q <= ST_DRAIN;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            ST_DRAIN: begin
               if (imem_ack) begin
                  state_q <= ST_FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pc_next_s;
               end else begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_HOLD: begin
               if (redirect_s || flush || !stall) begin
                  state_q <= ST_FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pc_next_s;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // IF/ID pipeline register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_q   <= 32'h0;
         pco_q   <= RESET_PC;
         valid_q <= 1'b0;
      end else if (flush) begin
         ins_q   <= 32'h0;
         valid_q <= 1'b0;
      end else if (redirect_s) begin
         valid_q <= 1'b0;
      end else if (accept_s && if_free_s) begin
         ins_q   <= imem_rdata;
         pco_q   <= addr_q;
         valid_q <= 1'b1;
      end else if ((state_q == ST_HOLD) && !stall) begin
         ins_q   <= skid_q;
         pco_q   <= skid_pc_q;
         valid_q <= 1'b1;
      end else if (!stall) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_q;
      end
   end

`ifdef FETCH_JUMP_PREDECODE_EN
   // Remembers that the J word now heading to decode has already redirected the PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jpre_q <= 1'b0;
      end else if (branch_valid || flush) begin
         jpre_q <= 1'b0;
      end else if (accept_s && predec_s) begin
         jpre_q <= 1'b1;
      end else if (jump_valid) begin
         jpre_q <= 1'b0;
      end else begin
         jpre_q <= jpre_q;
      end
   end
`endif

   assign imem_req      = req_q;
   assign imem_addr     = addr_q;
   assign inscode       = ins_q;
   assign pc_out        = pco_q;
   assign inscode_valid = valid_q;

endmodule
